// File: rtl/ahb_irq_ctrl.sv
// ahb_irq_ctrl: AHB-Lite interrupt controller for up to 32 peripheral sources.
//
// Each source is synchronised (SYNC_STAGES flops, 0 = bypass), XORed with its
// polarity bit and then fed to a per-source pending bit. In edge mode the bit
// latches rising edges and SWSET writes and is cleared by W1C writes. In level
// mode it simply follows the conditioned source. IRQ is the registered
// PENDING & ENABLE vector, and irq_any is the registered OR of that vector.
//
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,    AHB-Lite slave address/control (only HADDR[5:2]
//   HWRITE, HSIZE, HREADY   decoded, HSIZE ignored)
//   HWDATA / HRDATA         write / read data (data phase)
//   HREADYOUT, HRESP        always ready / always OKAY
//   src_i                   raw asynchronous interrupt sources
//   IRQ, irq_any            registered interrupt vector and combined flag
//
// Register map (word offsets):
//   0x00 RAW (RO)  0x04 ENABLE (RW)  0x08 MODE (RW, 1 = edge)
//   0x0C POLARITY (RW, 1 = active-low)  0x10 PENDING (R/W1C)
//   0x14 SWSET (WO)  0x18 ACTIVE (RO)  0x1C ID (RO)  0x20-0x3C read 0

module ahb_irq_ctrl #(
    parameter int unsigned N_SRC       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    input  logic [N_SRC-1:0] src_i,
    output logic [N_SRC-1:0] IRQ,
    output logic             irq_any
);

    localparam logic [3:0] AddrRaw    = 4'h0;
    localparam logic [3:0] AddrEnable = 4'h1;
    localparam logic [3:0] AddrMode   = 4'h2;
    localparam logic [3:0] AddrPol    = 4'h3;
    localparam logic [3:0] AddrPend   = 4'h4;
    localparam logic [3:0] AddrSwset  = 4'h5;
    localparam logic [3:0] AddrActive = 4'h6;
    localparam logic [3:0] AddrId     = 4'h7;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] sync;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync = src_i;
        end else begin : g_sync
            logic [N_SRC-1:0] stage_q [SYNC_STAGES];

            always_ff @(posedge HCLK) begin
                if (HRESET) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= src_i;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign sync = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // AHB address phase capture
    // ------------------------------------------------------------------
    logic [3:0] addr_q;
    logic       write_q;
    logic       valid_q;

    // A low HREADY belongs to another slave's data phase: hold what we have.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (HREADY) begin
            addr_q  <= HADDR[5:2];
            write_q <= HSEL & HTRANS[1] & HWRITE;
            valid_q <= HSEL & HTRANS[1];
        end
    end

    logic             wr_en;
    logic [N_SRC-1:0] wdata;

    assign wr_en = valid_q & write_q & HREADY;
    assign wdata = HWDATA[N_SRC-1:0];

    // ------------------------------------------------------------------
    // Configuration and pending state
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] enable_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] pol_q;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] cond;
    logic [N_SRC-1:0] cond_prev_q;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] swset;
    logic [N_SRC-1:0] irq_q;
    logic             irq_any_q;

    assign cond   = sync ^ pol_q;
    assign active = pend_q & enable_q;

    // Edge bits: the set term is ORed in after the clear, so set wins.
    // Level bits ignore W1C and SWSET and track the conditioned source.
    always_comb begin
        w1c    = '0;
        swset  = '0;
        if (wr_en && addr_q == AddrPend) begin
            w1c = wdata;
        end
        if (wr_en && addr_q == AddrSwset) begin
            swset = wdata;
        end
        pend_d = (mode_q & ((pend_q & ~w1c) | (cond & ~cond_prev_q) | swset))
               | (~mode_q & cond);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pol_q       <= '0;
            pend_q      <= '0;
            cond_prev_q <= '0;
            irq_q       <= '0;
            irq_any_q   <= 1'b0;
        end else begin
            if (wr_en && addr_q == AddrEnable) begin
                enable_q <= wdata;
            end
            if (wr_en && addr_q == AddrMode) begin
                mode_q <= wdata;
            end
            if (wr_en && addr_q == AddrPol) begin
                pol_q <= wdata;
            end
            pend_q      <= pend_d;
            cond_prev_q <= cond;
            irq_q       <= active;
            irq_any_q   <= |active;
        end
    end

    assign IRQ     = irq_q;
    assign irq_any = irq_any_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0]      id_word;
    logic [31:0]      rd_word;
    logic [N_SRC-1:0] reg_val;

    // Scan from the top so the lowest active index is the last one kept.
    always_comb begin
        id_word = 32'h8000_0000;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_word = {26'd0, 6'(i)};
            end
        end
    end

    always_comb begin
        reg_val = '0;
        rd_word = '0;
        case (addr_q)
            AddrRaw:    reg_val = sync;
            AddrEnable: reg_val = enable_q;
            AddrMode:   reg_val = mode_q;
            AddrPol:    reg_val = pol_q;
            AddrPend:   reg_val = pend_q;
            AddrActive: reg_val = active;
            default:    reg_val = '0;
        endcase
        rd_word[N_SRC-1:0] = reg_val;
        if (addr_q == AddrId) begin
            rd_word = id_word;
        end
    end

    assign HRDATA    = (valid_q & ~write_q) ? rd_word : 32'd0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[31:6], HADDR[1:0], HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahb_irq_ctrl.sv
// Directed bench for ahb_irq_ctrl. Two instances share one bus: a 16-source,
// two-stage-synchroniser instance and a 32-source, bypassed-synchroniser one.

module tb_ahb_irq_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] src;

    logic [31:0] hrdata16, hrdata32;
    logic        hreadyout16, hreadyout32, hresp16, hresp32;
    logic [15:0] irq16;
    logic [31:0] irq32;
    logic        any16, any32;

    int checks = 0;
    int errors = 0;

    logic [31:0] d16, d32;

    always #5 HCLK = ~HCLK;

    ahb_irq_ctrl #(.N_SRC(16), .SYNC_STAGES(2)) dut16 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(hrdata16), .HREADYOUT(hreadyout16), .HRESP(hresp16),
        .src_i(src[15:0]), .IRQ(irq16), .irq_any(any16)
    );

    ahb_irq_ctrl #(.N_SRC(32), .SYNC_STAGES(0)) dut32 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(hrdata32), .HREADYOUT(hreadyout32), .HRESP(hresp32),
        .src_i(src), .IRQ(irq32), .irq_any(any32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        tick();
        HWDATA = d; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] r16,
                            output logic [31:0] r32);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        r16 = hrdata16;
        r32 = hrdata32;
        tick();
    endtask

    // Write data phase overlapped with the address phase of a read to the same word.
    task automatic bus_wr_rd(input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] r16);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        tick();
        HWDATA = d; HWRITE = 1'b0; HADDR = a;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        r16 = hrdata16;
        tick();
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1; src = '0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Reset state
        chk("rst_irq16", 32'(irq16), 32'h0);
        chk("rst_any16", 32'(any16), 32'h0);
        chk("rst_irq32", irq32, 32'h0);
        chk("rst_hreadyout", 32'(hreadyout16), 32'h1);
        chk("rst_hresp", 32'(hresp16), 32'h0);
        chk("rst_hrdata_idle", hrdata16, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(32'(i * 4), d16, d32);
            chk($sformatf("rst_reg%0d", i), d16, (i == 7) ? 32'h8000_0000 : 32'h0);
        end

        // Edge mode, source 3, active-high, one-cycle pulse
        bus_write(32'h04, 32'h0008);
        bus_write(32'h08, 32'h0008);
        src[3] = 1'b1;
        tick();                         // edge k samples the pulse
        src[3] = 1'b0;
        tick();                         // k+1
        tick();                         // k+2: pending set, IRQ not yet
        chk("edge_irq_early", 32'(irq16), 32'h0);
        tick();                         // k+3
        chk("edge_irq_rise", 32'(irq16), 32'h0008);
        chk("edge_any", 32'(any16), 32'h1);
        bus_read(32'h10, d16, d32);
        chk("edge_pending", d16, 32'h0008);
        bus_read(32'h1C, d16, d32);
        chk("edge_id", d16, 32'h3);
        bus_read(32'h18, d16, d32);
        chk("edge_active", d16, 32'h0008);
        bus_write(32'h10, 32'h0008);
        chk("w1c_irq_hold", 32'(irq16), 32'h0008);
        tick();
        chk("w1c_irq_fall", 32'(irq16), 32'h0);

        // Level mode, source 5 active-low held asserted
        bus_write(32'h0C, 32'h0020);
        bus_write(32'h04, 32'h0028);
        repeat (3) tick();
        chk("lvl_irq", 32'(irq16), 32'h0020);
        bus_write(32'h10, 32'h0020);
        repeat (2) tick();
        chk("lvl_w1c_irq", 32'(irq16), 32'h0020);
        bus_read(32'h10, d16, d32);
        chk("lvl_w1c_pend", d16, 32'h0020);
        src[5] = 1'b1;                  // release (inactive for active-low)
        tick();                         // k
        tick();                         // k+1
        tick();                         // k+2
        chk("lvl_hold", 32'(irq16), 32'h0020);
        tick();                         // k+3
        chk("lvl_fall", 32'(irq16), 32'h0);

        // Priority and SWSET
        bus_write(32'h0C, 32'h0);
        src = '0;
        repeat (4) tick();
        bus_write(32'h08, 32'hFFFF);
        bus_write(32'h10, 32'hFFFF);
        bus_write(32'h04, 32'hFFFF);
        bus_write(32'h14, 32'h8104);
        bus_read(32'h1C, d16, d32);
        chk("prio_id2", d16, 32'h2);
        bus_read(32'h10, d16, d32);
        chk("swset_pend", d16, 32'h8104);
        chk("swset_irq", 32'(irq16), 32'h8104);
        bus_read(32'h14, d16, d32);
        chk("swset_reads0", d16, 32'h0);
        bus_write(32'h10, 32'h0004);
        bus_read(32'h1C, d16, d32);
        chk("prio_id8", d16, 32'h8);
        bus_write(32'h10, 32'hFFFF);
        bus_read(32'h1C, d16, d32);
        chk("prio_id_none", d16, 32'h8000_0000);
        chk("clr_any", 32'(any16), 32'h0);
        chk("clr_irq", 32'(irq16), 32'h0);

        // Edge on source 1 in the same cycle as W1C of bit 1: set wins
        bus_write(32'h14, 32'h0002);
        src[1] = 1'b1;
        tick();                         // edge k samples src[1]
        bus_write(32'h10, 32'h0002);    // commits at k+2, when the edge lands
        bus_read(32'h10, d16, d32);
        chk("simul_set_wins", d16, 32'h0002);
        src[1] = 1'b0;
        bus_write(32'h10, 32'h0002);
        bus_read(32'h10, d16, d32);
        chk("simul_then_clear", d16, 32'h0);

        // Bus corner cases
        bus_wr_rd(32'h04, 32'h1234, d16);
        chk("b2b_wr_rd", d16, 32'h1234);
        bus_write(32'h24, 32'hFFFF_FFFF);
        bus_read(32'h24, d16, d32);
        chk("unmapped_rd", d16, 32'h0);
        bus_read(32'h04, d16, d32);
        chk("unmapped_no_alias", d16, 32'h1234);

        // HREADY low from another slave holds the captured read phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h04;
        tick();
        HREADY = 1'b0; HADDR = 32'h1C;
        chk("hold_rd0", hrdata16, 32'h1234);
        tick();
        chk("hold_rd1", hrdata16, 32'h1234);
        HREADY = 1'b1; HSEL = 1'b0; HTRANS = 2'b00;
        tick();

        // Reset during a write data phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        tick();
        HWDATA = 32'h00AA; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        bus_read(32'h04, d16, d32);
        chk("rst_abort_write", d16, 32'h0);

        // 32 sources, synchroniser bypassed: IRQ one edge after sampling
        bus_write(32'h08, 32'hFFFF_FFFF);
        bus_write(32'h04, 32'h8000_0000);
        src[31] = 1'b1;
        tick();                         // edge k: pending set
        chk("s0_irq_early", irq32, 32'h0);
        tick();                         // k+1
        chk("s0_irq_rise", irq32, 32'h8000_0000);
        chk("s0_any", 32'(any32), 32'h1);
        src[31] = 1'b0;
        bus_read(32'h10, d16, d32);
        chk("s0_pending", d32, 32'h8000_0000);
        bus_read(32'h1C, d16, d32);
        chk("s0_id31", d32, 32'h1F);
        chk("s0_irq16_quiet", 32'(irq16), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
